switch_allocator: RTL and testbench

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/switch_allocator_pkg.sv | 19 +
 rtl/switch_allocator_if.sv | 34 +++
 rtl/switch_allocator_rr_arbiter.sv | 32 +++
 rtl/switch_allocator.sv | 126 ++++++++++++
 tb/tb_switch_allocator.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_allocator_pkg.sv
// Shared NoC definitions for the switch allocator: default port count,
// port-index width derivation and the per-output lock state.
package switch_allocator_pkg;

  localparam int NUM_PORTS_DEF = 5;

  // A single-port router still needs a 1-bit index field.
  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PORT_W_DEF = port_w(NUM_PORTS_DEF);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } out_state_e;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffer units, the switch allocator
// and the crossbar.
//   req[i]      input i wants the switch
//   dest[i]     output port requested by input i (valid while req[i]=1)
//   tail[i]     flit crossing from input i this cycle is the packet tail
//   grant[i]    input i owns an output (registered)
//   out_valid[o] output o is locked to an input
//   out_sel[o]  input index driving output o (crossbar select)
//   dest_err    some requesting input named a non-existent output this cycle
// master = requester/crossbar side, slave = allocator.
interface switch_allocator_if
  import switch_allocator_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int PORT_W    = PORT_W_DEF
);
  logic [NUM_PORTS-1:0]             req;
  logic [NUM_PORTS-1:0][PORT_W-1:0] dest;
  logic [NUM_PORTS-1:0]             tail;
  logic [NUM_PORTS-1:0]             grant;
  logic [NUM_PORTS-1:0]             out_valid;
  logic [NUM_PORTS-1:0][PORT_W-1:0] out_sel;
  logic                             dest_err;

  modport master (
    output req, dest, tail,
    input  grant, out_valid, out_sel, dest_err
  );

  modport slave (
    input  req, dest, tail,
    output grant, out_valid, out_sel, dest_err
  );
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin search for one output port.
//   req  candidate inputs for this output
//   ptr  last owner; search starts at (ptr+1) mod N and wraps
//   gnt  one-hot winner, idx its index, any = some candidate present
module rr_arbiter
  import switch_allocator_pkg::*;
#(
  parameter int N = NUM_PORTS_DEF,
  parameter int W = port_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: one lock FSM per output port. An idle output picks a
// requesting, not-yet-granted input round-robin and stays locked to it until
// the tail flit crosses or the owner drops its request.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   request/grant bundle (slave side)
//
// state     | meaning
// ST_IDLE   | output free, arbitrating among eligible requests
// ST_LOCKED | output owned by owner_q; grant/out_sel held until release/abort
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int PORT_W    = port_w(NUM_PORTS)
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);
  out_state_e           state_q [NUM_PORTS];
  out_state_e           state_d [NUM_PORTS];
  logic [PORT_W-1:0]    owner_q [NUM_PORTS];
  logic [PORT_W-1:0]    owner_d [NUM_PORTS];
  logic [PORT_W-1:0]    ptr_q   [NUM_PORTS];
  logic [PORT_W-1:0]    ptr_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant_q;
  logic [NUM_PORTS-1:0] grant_d;

  logic [NUM_PORTS-1:0] dest_in_range;
  logic [NUM_PORTS-1:0] cand     [NUM_PORTS];
  logic [NUM_PORTS-1:0] owner_oh [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_gnt  [NUM_PORTS];
  logic [PORT_W-1:0]    arb_idx  [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_any;

  always_comb begin
    dest_in_range = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      dest_in_range[i] = (int'(bus.dest[i]) < NUM_PORTS);
    end
  end

  assign bus.dest_err = |(bus.req & ~dest_in_range);

  // An input already holding a grant is invisible to every arbiter, which is
  // what keeps each input to a single grant.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      cand[o]     = '0;
      owner_oh[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[o][i]     = bus.req[i] && dest_in_range[i] &&
                         (int'(bus.dest[i]) == o) && !grant_q[i];
        owner_oh[o][i] = (int'(owner_q[o]) == i);
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter #(.N(NUM_PORTS), .W(PORT_W)) u_rr_arbiter (
      .req (cand[o]),
      .ptr (ptr_q[o]),
      .gnt (arb_gnt[o]),
      .idx (arb_idx[o]),
      .any (arb_any[o])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= PORT_W'(NUM_PORTS - 1);
      end
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // A releasing output goes IDLE for one cycle before it can arbitrate
  // again, so a request arriving alongside the release sees the new pointer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      case (state_q[o])
        ST_IDLE: begin
          if (arb_any[o]) begin
            state_d[o] = ST_LOCKED;
            owner_d[o] = arb_idx[o];
            grant_d    = grant_d | arb_gnt[o];
          end
        end
        ST_LOCKED: begin
          if (!(|(bus.req & owner_oh[o])) || (|(bus.tail & owner_oh[o]))) begin
            state_d[o] = ST_IDLE;
            ptr_d[o]   = owner_q[o];
            owner_d[o] = '0;
          end else begin
            grant_d = grant_d | owner_oh[o];
          end
        end
        default: state_d[o] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.grant     = grant_q;
    bus.out_valid = '0;
    bus.out_sel   = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      bus.out_valid[o] = (state_q[o] == ST_LOCKED);
      bus.out_sel[o]   = owner_q[o];
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  localparam int N = NUM_PORTS_DEF;
  localparam int W = PORT_W_DEF;

  typedef struct {
    logic [N-1:0]        grant;
    logic [N-1:0]        valid;
    logic [N-1:0][W-1:0] sel;
    logic                derr;
  } exp_t;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic rst_req = 1'b0;

  always #5 clk = ~clk;

  switch_allocator_if #(.NUM_PORTS(N), .PORT_W(W)) bus ();

  switch_allocator #(.NUM_PORTS(N), .PORT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t e;

  // reference model: per output, current owner (-1 = free) and last owner
  int m_owner [N];
  int m_last  [N];

  // packet engine: each input sends packets of len flits to cur_dest
  bit active [N];
  int cur_dest [N], len [N], sent [N], abort_at [N], waitc [N];
  int pkts [N], pdest [N], plen [N], pabort [N];
  bit rnd_mode = 1'b0;

  int   log_sel[$];
  int   log_cyc[$];
  int   exp_log[$];
  logic prev_v2 = 1'b0;

  task automatic chk(string name, int act, int req_v);
    checks++;
    if (act != req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_owner[o] = -1;
      m_last[o]  = N - 1;
    end
  endtask

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    for (int o = 0; o < N; o++) if (m_owner[o] >= 0) g[m_owner[o]] = 1'b1;
    return g;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0][W-1:0] d,
                            input logic [N-1:0] t);
    bit busy [N];
    int nxt  [N];
    for (int i = 0; i < N; i++) busy[i] = 1'b0;
    for (int o = 0; o < N; o++) if (m_owner[o] >= 0) busy[m_owner[o]] = 1'b1;
    for (int o = 0; o < N; o++) begin
      nxt[o] = m_owner[o];
      if (m_owner[o] >= 0) begin
        if (!r[m_owner[o]] || t[m_owner[o]]) begin
          nxt[o]    = -1;
          m_last[o] = m_owner[o];
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last[o] + k) % N;
          if (nxt[o] < 0 && r[i] && int'(d[i]) == o && !busy[i]) nxt[o] = i;
        end
      end
    end
    for (int o = 0; o < N; o++) m_owner[o] = nxt[o];
  endtask

  task automatic start_pkt(input int i, input int dst, input int l, input int ab);
    active[i]   = 1'b1;
    cur_dest[i] = dst;
    len[i]      = l;
    sent[i]     = 0;
    abort_at[i] = ab;
    waitc[i]    = 0;
  endtask

  task automatic set_pkt(input int i, input int dst, input int l, input int ab, input int n);
    pdest[i]  = dst;
    plen[i]   = l;
    pabort[i] = ab;
    pkts[i]   = n;
  endtask

  task automatic clear_engine();
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0;
      pkts[i]   = 0;
    end
  endtask

  function automatic bit busy_any();
    bit b;
    b = 1'b0;
    for (int i = 0; i < N; i++) if (active[i] || pkts[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic step();
    logic [N-1:0]        mg, r, t;
    logic [N-1:0][W-1:0] d;
    exp_t                x;
    @(posedge clk);
    #1;
    rst = rst_req;
    if (!rst) model_reset();
    mg = model_grant();
    r  = '0;
    t  = '0;
    d  = '0;
    for (int i = 0; i < N; i++) begin
      if (!active[i]) begin
        if (pkts[i] > 0) begin
          pkts[i]--;
          start_pkt(i, pdest[i], plen[i], pabort[i]);
        end else if (rnd_mode && $urandom_range(0, 3) == 0) begin
          start_pkt(i,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(N, 7))
                                                : int'($urandom_range(0, N - 1)),
                    int'($urandom_range(1, 4)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
        end
      end
      d[i] = W'(cur_dest[i]);
      if (active[i]) begin
        r[i] = 1'b1;
        if (mg[i] && sent[i] == abort_at[i]) r[i] = 1'b0;
        if (!mg[i] && waitc[i] >= 30) r[i] = 1'b0;
        if (mg[i] && rnd_mode && $urandom_range(0, 7) == 0) d[i] = W'($urandom_range(0, 7));
      end else if (rnd_mode) begin
        d[i] = W'($urandom_range(0, 7));
      end
      t[i] = mg[i] ? (active[i] && sent[i] == len[i] - 1) : 1'($urandom_range(0, 1));
    end
    bus.req  = r;
    bus.dest = d;
    bus.tail = t;

    x.grant = mg;
    x.derr  = 1'b0;
    for (int i = 0; i < N; i++) if (r[i] && int'(d[i]) >= N) x.derr = 1'b1;
    for (int o = 0; o < N; o++) begin
      x.valid[o] = (m_owner[o] >= 0);
      x.sel[o]   = (m_owner[o] >= 0) ? W'(m_owner[o]) : '0;
    end
    sb.push_back(x);

    if (rst) begin
      model_step(r, d, t);
      for (int i = 0; i < N; i++) begin
        if (active[i]) begin
          if (!r[i]) active[i] = 1'b0;
          else if (mg[i]) begin
            sent[i]++;
            if (t[i]) active[i] = 1'b0;
          end else waitc[i]++;
        end
      end
    end
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy_any() && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    checks++;
    if (busy_any()) begin
      failures++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
      clear_engine();
    end
  endtask

  task automatic check_log(input string name, input int gap);
    chk({name, "_count"}, log_sel.size(), exp_log.size());
    for (int k = 0; k < exp_log.size() && k < log_sel.size(); k++) begin
      chk($sformatf("%s_order%0d", name, k), log_sel[k], exp_log[k]);
      if (k > 0) chk($sformatf("%s_gap%0d", name, k), log_cyc[k] - log_cyc[k-1], gap);
    end
    log_sel.delete();
    log_cyc.delete();
    exp_log.delete();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant", int'(bus.grant), int'(e.grant));
      chk("out_valid", int'(bus.out_valid), int'(e.valid));
      chk("dest_err", int'(bus.dest_err), int'(e.derr));
      for (int o = 0; o < N; o++)
        if (e.valid[o]) chk($sformatf("out_sel%0d", o), int'(bus.out_sel[o]), int'(e.sel[o]));
    end
    if (bus.out_valid[2] && !prev_v2) begin
      log_sel.push_back(int'(bus.out_sel[2]));
      log_cyc.push_back(cyc);
    end
    prev_v2 = bus.out_valid[2];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req  = '0;
    bus.dest = '0;
    bus.tail = '0;
    model_reset();
    clear_engine();

    // all inputs request output 2 while held in reset
    for (int i = 0; i < N; i++) set_pkt(i, 2, 1, -1, 1);
    rst_req = 1'b0;
    repeat (4) step();
    chk("reset_grant", int'(bus.grant), 0);
    chk("reset_valid", int'(bus.out_valid), 0);
    rst_req = 1'b1;
    run_until_idle("reset_release", 60);
    exp_log = {0, 1, 2, 3, 4};
    check_log("rr_after_reset", 2);

    // three inputs, two 2-flit packets each, all to output 2
    set_pkt(0, 2, 2, -1, 2);
    set_pkt(2, 2, 2, -1, 2);
    set_pkt(4, 2, 2, -1, 2);
    run_until_idle("contention", 80);
    exp_log = {0, 2, 4, 0, 2, 4};
    check_log("contention", 3);

    // single 5-flit packet
    set_pkt(1, 3, 5, -1, 1);
    run_until_idle("single", 30);

    // non-conflicting requests
    set_pkt(0, 1, 3, -1, 1);
    set_pkt(3, 4, 3, -1, 1);
    run_until_idle("parallel", 30);

    // aborts and bad destination
    set_pkt(2, 0, 10, 2, 1);
    set_pkt(1, 7, 1, -1, 1);
    set_pkt(3, 4, 3, 0, 1);
    run_until_idle("abort_err", 80);

    // asynchronous reset while output 2 is locked to input 4
    log_sel.delete();
    log_cyc.delete();
    set_pkt(4, 2, 40, -1, 1);
    repeat (4) step();
    chk("locked_before_rst", int'(bus.out_valid[2]), 1);
    chk("owner_before_rst", int'(bus.out_sel[2]), 4);
    @(negedge clk);
    #2;
    rst     = 1'b0;
    rst_req = 1'b0;
    #1;
    chk("async_rst_grant4", int'(bus.grant[4]), 0);
    chk("async_rst_valid2", int'(bus.out_valid[2]), 0);
    clear_engine();
    repeat (3) step();
    rst_req = 1'b1;
    repeat (2) step();
    log_sel.delete();
    log_cyc.delete();

    // randomized traffic
    rnd_mode = 1'b1;
    repeat (3000) step();
    rnd_mode = 1'b0;
    run_until_idle("random_drain", 100);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
